// File: rtl/sync_spi_slave_w_if.sv
// Bundle of SPI pins plus the TX/RX word handshake for sync_spi_slave_w.
// slave is the DUT view; master is the view of the pin driver / command decoder.
interface sync_spi_slave_w_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sck;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             frame_abort;
  logic             frame_active;

  modport slave (
    input  sck, cs, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, frame_active
  );

  modport master (
    output sck, cs, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, frame_active
  );
endinterface

// File: rtl/sync_spi_slave_w.sv
// Oversampled SPI slave: any word width, all four modes, MSB/LSB first, bursts,
// one-deep TX holding register with underrun and frame-abort reporting.
module sync_spi_slave_w #(
  parameter int unsigned WIDTH       = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          LSB_FIRST   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  sync_spi_slave_w_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_sync_vld;
  logic                   r_sck_d, r_armed, r_frame_active;
  logic [CntW-1:0]        r_bit_cnt;
  logic [WIDTH-1:0]       r_tx_shift, r_rx_shift, r_hold, r_rx_data;
  logic                   r_hold_full, r_miso, r_rx_valid, r_tx_underrun, r_frame_abort;

  logic             w_sck_s, w_cs_s, w_mosi_s, w_sck_n, w_sck_n_d, w_act;
  logic             w_lead, w_trail, w_sample, w_launch, w_cs_fall, w_cs_rise;
  logic             w_load, w_shift, w_write, w_out_bit;
  logic [WIDTH-1:0] w_tx_next, w_rx_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= {SYNC_STAGES{CPOL}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sync_vld  <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_n   = w_sck_s ^ CPOL;
  assign w_sck_n_d = r_sck_d ^ CPOL;

  // Frames count only once CS has been seen high after the reset values flushed out.
  assign w_act     = r_armed & ~w_cs_s;
  assign w_cs_fall = w_act & ~r_frame_active;
  assign w_cs_rise = ~w_act & r_frame_active;
  assign w_lead    = w_act & w_sck_n & ~w_sck_n_d;
  assign w_trail   = w_act & ~w_sck_n & w_sck_n_d;
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_launch  = CPHA ? w_lead : w_trail;

  assign w_load  = (w_cs_fall & ~CPHA) | (w_launch & (r_bit_cnt == '0));
  assign w_shift = w_launch & (r_bit_cnt != '0);
  assign w_write = bus.tx_valid & ~r_hold_full;

  always_comb begin
    w_tx_next = r_tx_shift;
    if (w_load) begin
      w_tx_next = r_hold_full ? r_hold : '0;
    end else if (w_shift) begin
      w_tx_next = LSB_FIRST ? {1'b0, r_tx_shift[WIDTH-1:1]} : {r_tx_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign w_out_bit = LSB_FIRST ? w_tx_next[0] : w_tx_next[WIDTH-1];
  assign w_rx_next = LSB_FIRST ? {w_mosi_s, r_rx_shift[WIDTH-1:1]}
                               : {r_rx_shift[WIDTH-2:0], w_mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_d        <= CPOL;
      r_armed        <= 1'b0;
      r_frame_active <= 1'b0;
      r_bit_cnt      <= '0;
      r_tx_shift     <= '0;
      r_rx_shift     <= '0;
      r_hold         <= '0;
      r_hold_full    <= 1'b0;
      r_rx_data      <= '0;
      r_miso         <= 1'b0;
      r_rx_valid     <= 1'b0;
      r_tx_underrun  <= 1'b0;
      r_frame_abort  <= 1'b0;
    end else begin
      r_sck_d        <= w_sck_s;
      r_armed        <= r_armed | (r_sync_vld[SYNC_STAGES-1] & w_cs_s);
      r_frame_active <= w_act;
      r_tx_shift     <= w_tx_next;
      r_miso         <= w_act & w_out_bit;
      r_rx_valid     <= 1'b0;
      r_tx_underrun  <= w_load & ~r_hold_full;
      r_frame_abort  <= 1'b0;

      // A write can only land while holding is empty, so it never races a consuming load.
      if (w_write) begin
        r_hold      <= bus.tx_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_sample) begin
        r_rx_shift <= w_rx_next;
        if (r_bit_cnt == LastBit) begin
          r_bit_cnt  <= '0;
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      if (w_cs_rise) begin
        r_frame_abort <= (r_bit_cnt != '0);
        r_bit_cnt     <= '0;
        r_rx_shift    <= '0;
      end
    end
  end

  assign bus.miso         = r_miso;
  assign bus.miso_oe      = r_frame_active;
  assign bus.tx_ready     = ~r_hold_full;
  assign bus.rx_data      = r_rx_data;
  assign bus.rx_valid     = r_rx_valid;
  assign bus.tx_underrun  = r_tx_underrun;
  assign bus.frame_abort  = r_frame_abort;
  assign bus.frame_active = r_frame_active;
endmodule

// File: tb/tb_sync_spi_slave_w.sv
// Directed bench: three slave instances (mode 0 W8 MSB, mode 3 W16 LSB, mode 1 W8 MSB)
// sharing SCK/MOSI, each with its own CS and TX handshake.
module tb_sync_spi_slave_w;
  localparam int Half = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic [2:0]  cs = 3'b111;
  logic [2:0]  tx_valid = 3'b000;
  logic [15:0] tx_data [3];

  logic [2:0]  w_miso, w_oe, w_ready, w_rxv, w_unr, w_abt, w_fa;
  logic [15:0] w_rxd [3];

  int checks = 0;
  int errors = 0;
  int rx_cnt [3] = '{0, 0, 0};
  int unr_cnt [3] = '{0, 0, 0};
  int abt_cnt [3] = '{0, 0, 0};
  int acc_cnt [3] = '{0, 0, 0};
  logic [15:0] rx_log [3][32];
  logic [15:0] g_mosi [4];
  logic [15:0] g_miso [4];
  logic [15:0] g_tx [4];
  int g_unr_snap;

  always #5 clk = ~clk;

  sync_spi_slave_w_if #(.WIDTH(8))  if_a ();
  sync_spi_slave_w_if #(.WIDTH(16)) if_b ();
  sync_spi_slave_w_if #(.WIDTH(8))  if_c ();

  sync_spi_slave_w #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(2))
    u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  sync_spi_slave_w #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1), .SYNC_STAGES(2))
    u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  sync_spi_slave_w #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b0), .SYNC_STAGES(2))
    u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.sck = sck;
  assign if_b.sck = sck;
  assign if_c.sck = sck;
  assign if_a.mosi = mosi;
  assign if_b.mosi = mosi;
  assign if_c.mosi = mosi;
  assign if_a.cs = cs[0];
  assign if_b.cs = cs[1];
  assign if_c.cs = cs[2];
  assign if_a.tx_valid = tx_valid[0];
  assign if_b.tx_valid = tx_valid[1];
  assign if_c.tx_valid = tx_valid[2];
  assign if_a.tx_data = tx_data[0][7:0];
  assign if_b.tx_data = tx_data[1];
  assign if_c.tx_data = tx_data[2][7:0];

  assign w_miso  = {if_c.miso, if_b.miso, if_a.miso};
  assign w_oe    = {if_c.miso_oe, if_b.miso_oe, if_a.miso_oe};
  assign w_ready = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
  assign w_rxv   = {if_c.rx_valid, if_b.rx_valid, if_a.rx_valid};
  assign w_unr   = {if_c.tx_underrun, if_b.tx_underrun, if_a.tx_underrun};
  assign w_abt   = {if_c.frame_abort, if_b.frame_abort, if_a.frame_abort};
  assign w_fa    = {if_c.frame_active, if_b.frame_active, if_a.frame_active};
  assign w_rxd[0] = {8'h00, if_a.rx_data};
  assign w_rxd[1] = if_b.rx_data;
  assign w_rxd[2] = {8'h00, if_c.rx_data};

  // Event monitor, sampled just after the falling clock edge.
  always @(negedge clk) begin
    #1;
    for (int s = 0; s < 3; s++) begin
      if (w_rxv[s]) begin
        rx_log[s][rx_cnt[s] % 32] = w_rxd[s];
        rx_cnt[s]++;
      end
      if (w_unr[s]) unr_cnt[s]++;
      if (w_abt[s]) abt_cnt[s]++;
      if (tx_valid[s] && w_ready[s]) acc_cnt[s]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer g_tx[0..n-1] on the handshake, each held until accepted.
  task automatic feed(input int sel, input int n);
    int guard;
    for (int k = 0; k < n; k++) begin
      tx_data[sel] = g_tx[k];
      tx_valid[sel] = 1'b1;
      guard = 0;
      while (!w_ready[sel] && guard < 2000) begin
        cyc(1);
        guard++;
      end
      chk("feed_ready", {31'd0, w_ready[sel]}, 32'd1);
      cyc(1);
    end
    tx_valid[sel] = 1'b0;
  endtask

  // Master side: clocks g_mosi words out, captures MISO into g_miso; stop_bits>0 aborts early.
  task automatic spi_xfer(input int sel, input int nw, input int stop_bits);
    bit cpol, cpha, lsb;
    int wd, total, w, b, pos;
    cpol = (sel == 1);
    cpha = (sel != 0);
    lsb  = (sel == 1);
    wd   = (sel == 1) ? 16 : 8;
    total = (stop_bits > 0) ? stop_bits : nw * wd;
    for (int k = 0; k < 4; k++) g_miso[k] = '0;
    sck = cpol;
    cyc(Half);
    cs[sel] = 1'b0;
    for (int i = 0; i < total; i++) begin
      w = i / wd;
      b = i % wd;
      pos = lsb ? b : wd - 1 - b;
      if (!cpha) begin
        mosi = g_mosi[w][pos];
        cyc(Half);
        g_miso[w][pos] = w_miso[sel];
        sck = ~cpol;
        cyc(Half);
        if (i == total - 1) g_unr_snap = unr_cnt[sel];
        sck = cpol;
      end else begin
        cyc(Half);
        sck = ~cpol;
        mosi = g_mosi[w][pos];
        cyc(Half);
        g_miso[w][pos] = w_miso[sel];
        sck = cpol;
      end
    end
    cyc(Half);
    if (cpha) g_unr_snap = unr_cnt[sel];
    chk("frame_active_in_frame", {31'd0, w_fa[sel]}, 32'd1);
    chk("miso_oe_in_frame", {31'd0, w_oe[sel]}, 32'd1);
    cs[sel] = 1'b1;
    cyc(Half + 4);
    chk("frame_active_idle", {31'd0, w_fa[sel]}, 32'd0);
    chk("miso_idle", {31'd0, w_miso[sel]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, ub, ab, cb;
    tx_data[0] = '0;
    tx_data[1] = '0;
    tx_data[2] = '0;
    cyc(3);
    // Reset values
    chk("rst_miso", {31'd0, w_miso[0]}, 32'd0);
    chk("rst_miso_oe", {31'd0, w_oe[0]}, 32'd0);
    chk("rst_tx_ready", {29'd0, w_ready}, 32'd7);
    chk("rst_rx_data", {16'd0, w_rxd[0]}, 32'd0);
    chk("rst_rx_valid", {29'd0, w_rxv}, 32'd0);
    chk("rst_underrun", {29'd0, w_unr}, 32'd0);
    chk("rst_abort", {29'd0, w_abt}, 32'd0);
    chk("rst_frame_active", {29'd0, w_fa}, 32'd0);
    reset = 1'b0;
    cyc(10);

    // Mode 0, W8, MSB first, two-word burst
    g_tx[0] = 16'h00A5;
    feed(0, 1);
    chk("m0_ready_after_accept", {31'd0, w_ready[0]}, 32'd0);
    g_tx[0] = 16'h003C;
    g_mosi[0] = 16'h005A;
    g_mosi[1] = 16'h00C3;
    rb = rx_cnt[0];
    ub = unr_cnt[0];
    fork
      feed(0, 1);
      spi_xfer(0, 2, 0);
    join
    chk("m0_miso_w0", {16'd0, g_miso[0]}, 32'h00A5);
    chk("m0_miso_w1", {16'd0, g_miso[1]}, 32'h003C);
    chk("m0_rx_count", rx_cnt[0] - rb, 32'd2);
    chk("m0_rx_w0", {16'd0, rx_log[0][rb % 32]}, 32'h005A);
    chk("m0_rx_w1", {16'd0, rx_log[0][(rb + 1) % 32]}, 32'h00C3);
    chk("m0_no_underrun", g_unr_snap - ub, 32'd0);
    chk("m0_rx_data_hold", {16'd0, w_rxd[0]}, 32'h00C3);

    // Mode 3, W16, LSB first
    g_tx[0] = 16'h1234;
    feed(1, 1);
    g_mosi[0] = 16'hBEEF;
    rb = rx_cnt[1];
    spi_xfer(1, 1, 0);
    chk("m3_miso", {16'd0, g_miso[0]}, 32'h1234);
    chk("m3_rx_count", rx_cnt[1] - rb, 32'd1);
    chk("m3_rx_data", {16'd0, w_rxd[1]}, 32'hBEEF);

    // Underrun on the second load of a mode 1 burst
    g_tx[0] = 16'h0081;
    feed(2, 1);
    g_mosi[0] = 16'h0011;
    g_mosi[1] = 16'h0022;
    rb = rx_cnt[2];
    ub = unr_cnt[2];
    spi_xfer(2, 2, 0);
    chk("unr_miso_w0", {16'd0, g_miso[0]}, 32'h0081);
    chk("unr_miso_w1", {16'd0, g_miso[1]}, 32'h0000);
    chk("unr_pulses", g_unr_snap - ub, 32'd1);
    chk("unr_tx_ready", {31'd0, w_ready[2]}, 32'd1);
    chk("unr_rx_w0", {16'd0, rx_log[2][rb % 32]}, 32'h0011);
    chk("unr_rx_w1", {16'd0, rx_log[2][(rb + 1) % 32]}, 32'h0022);

    // Abort after 5 of 8 bits, then a clean frame
    g_mosi[0] = 16'h00FF;
    rb = rx_cnt[0];
    ab = abt_cnt[0];
    spi_xfer(0, 1, 5);
    chk("abort_pulse", abt_cnt[0] - ab, 32'd1);
    chk("abort_no_rx", rx_cnt[0] - rb, 32'd0);
    g_tx[0] = 16'h0069;
    feed(0, 1);
    g_mosi[0] = 16'h0096;
    ab = abt_cnt[0];
    spi_xfer(0, 1, 0);
    chk("post_abort_miso", {16'd0, g_miso[0]}, 32'h0069);
    chk("post_abort_rx_count", rx_cnt[0] - rb, 32'd1);
    chk("post_abort_rx", {16'd0, w_rxd[0]}, 32'h0096);
    chk("post_abort_no_abort", abt_cnt[0] - ab, 32'd0);

    // Backpressure across a three-word mode 1 burst
    cb = acc_cnt[2];
    ub = unr_cnt[2];
    rb = rx_cnt[2];
    g_tx[0] = 16'h00A1;
    feed(2, 1);
    chk("bp_ready_low_before_load", {31'd0, w_ready[2]}, 32'd0);
    g_tx[0] = 16'h00B2;
    g_tx[1] = 16'h00C3;
    g_mosi[0] = 16'h000F;
    g_mosi[1] = 16'h00F0;
    g_mosi[2] = 16'h003C;
    fork
      feed(2, 2);
      spi_xfer(2, 3, 0);
    join
    chk("bp_accepts", acc_cnt[2] - cb, 32'd3);
    chk("bp_miso_w0", {16'd0, g_miso[0]}, 32'h00A1);
    chk("bp_miso_w1", {16'd0, g_miso[1]}, 32'h00B2);
    chk("bp_miso_w2", {16'd0, g_miso[2]}, 32'h00C3);
    chk("bp_no_underrun", unr_cnt[2] - ub, 32'd0);
    chk("bp_rx_count", rx_cnt[2] - rb, 32'd3);
    chk("bp_rx_w2", {16'd0, rx_log[2][(rb + 2) % 32]}, 32'h003C);

    // Asynchronous reset mid-word in mode 1
    g_tx[0] = 16'h00FF;
    feed(2, 1);
    sck = 1'b0;
    cyc(Half);
    cs[2] = 1'b0;
    cyc(Half);
    sck = 1'b1;
    mosi = 1'b1;
    cyc(Half);
    chk("pre_rst_miso", {31'd0, w_miso[2]}, 32'd1);
    chk("pre_rst_frame_active", {31'd0, w_fa[2]}, 32'd1);
    chk("pre_rst_rx_data", {16'd0, w_rxd[2]}, 32'h003C);
    sck = 1'b0;
    cyc(Half);
    sck = 1'b1;
    cyc(3);
    reset = 1'b1;
    #1;
    chk("arst_miso", {31'd0, w_miso[2]}, 32'd0);
    chk("arst_miso_oe", {31'd0, w_oe[2]}, 32'd0);
    chk("arst_frame_active", {31'd0, w_fa[2]}, 32'd0);
    chk("arst_tx_ready", {31'd0, w_ready[2]}, 32'd1);
    chk("arst_rx_data", {16'd0, w_rxd[2]}, 32'd0);
    cyc(2);
    reset = 1'b0;
    sck = 1'b0;
    rb = rx_cnt[2];
    cyc(12);
    chk("post_rst_unarmed", {31'd0, w_fa[2]}, 32'd0);
    cs[2] = 1'b1;
    cyc(Half);
    g_tx[0] = 16'h003A;
    feed(2, 1);
    g_mosi[0] = 16'h00C5;
    spi_xfer(2, 1, 0);
    chk("post_rst_miso", {16'd0, g_miso[0]}, 32'h003A);
    chk("post_rst_rx_count", rx_cnt[2] - rb, 32'd1);
    chk("post_rst_rx", {16'd0, w_rxd[2]}, 32'h00C5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_spi_slave_w.md
Name: sync_spi_slave_w

Overview:
- Parametrised successor to the byte-wide synchronous SPI slave.
- Oversamples SCK, CS and MOSI with the system clock, so no second clock domain exists.
- Supports any word width, all four SPI modes, MSB- or LSB-first ordering and multi-word bursts within one CS assertion.
- Has a one-deep TX holding register with a valid/ready handshake, plus underrun and frame-abort reporting.
- Sits between the external SPI master pins and the register/command decoder.

Parameters:
- WIDTH, 8: bits per SPI word (≥2).
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- LSB_FIRST, 0: 1 = shift LSB first on both MOSI and MISO.
- SYNC_STAGES, 2: synchroniser flops on sck, cs and mosi (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock pin.
- cs  in  1  chip select pin, active low.
- mosi  in  1  SPI data in.
- miso  out  1  SPI data out.
- miso_oe  out  1  MISO output enable, high while the frame is active.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when a word is launched with the holding register empty.
- frame_abort  out  1  one-cycle pulse when CS deasserts mid-word.
- frame_active  out  1  synchronised CS is asserted.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0, frame_active=0.
- Reset internal state: holding empty, bit_cnt=0, shift registers=0, synchronisers set to idle (cs=1, sck=CPOL).
- Synchronisation: sck, cs and mosi each pass through SYNC_STAGES flops.
- Edge detection: sck_n = sck_s ^ CPOL. Leading edge = rise of sck_n; trailing edge = fall of sck_n.
- Sample edge is the leading edge if CPHA=0, otherwise the trailing edge. Launch edge is the opposite edge.
- Edges are acted on only while synchronised CS is low.
- Required SCK timing: each SCK half-period ≥ SYNC_STAGES+2 clk cycles.
- TX handshake: a write occurs when tx_valid && tx_ready; tx_data enters holding and tx_ready drops the next cycle.
- Holding is consumed by a word load; tx_ready rises the cycle after the load.
- No bypass: if a write and a load occur in the same cycle with holding empty, the load underruns and the write fills holding.
- Word load: tx shift register ← holding (or all zeros plus a tx_underrun pulse if holding is empty). Load occurs:
  (a) on the CS falling edge (synchronised), CPHA=0 only;
  (b) on any launch edge with bit_cnt==0, for CPHA=1 always, and for CPHA=0 after the first word.
- On a launch edge with bit_cnt≠0, the tx shift register shifts by one position (direction per LSB_FIRST).
- miso is registered from the current output bit: MSB if LSB_FIRST=0, LSB otherwise.
- miso_oe = frame_active. While CS is high, miso=0.
- Sample edge: the synchronised mosi bit is shifted into the rx shift register and bit_cnt increments.
- When bit_cnt wraps from WIDTH-1 to 0:
  - rx_data ← completed word, registered in the same cycle as the shift;
  - rx_valid pulses one cycle, SYNC_STAGES+1 clk cycles after the SCK pin edge;
  - rx_data holds until the next completed word.
- CS rising edge (synchronised):
  - if bit_cnt≠0: frame_abort pulses, the partial rx word is discarded, no rx_valid is issued, and a word already loaded counts as consumed;
  - in all cases bit_cnt←0;
  - holding contents are preserved.
- Bursts: words continue back-to-back with no gap while CS stays low; each word boundary performs one load.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and the frame in progress is lost.
- Sample edges arriving after reset with CS low are handled as a fresh frame only after CS has been observed high then low.

Test Plan:
- Mode 0, WIDTH=8, MSB first:
  - stimulus: preload tx 0xA5 then 0x3C; master sends 0x5A, 0xC3 in one CS frame.
  - response: MISO carries 0xA5, 0x3C; rx_valid pulses twice with rx_data 0x5A then 0xC3; no underrun.
- Mode 3, WIDTH=16, LSB_FIRST=1:
  - stimulus: tx 0x1234; master sends 0xBEEF.
  - response: MISO bit sequence is 0x1234 LSB first; rx_data=0xBEEF.
- Underrun:
  - stimulus: holding empty at the second word load of a 2-word burst.
  - response: tx_underrun pulses once; second MISO word is 0x00; tx_ready remains 1.
- Abort:
  - stimulus: CS deasserts after 5 of 8 bits.
  - response: frame_abort pulses; no rx_valid; next frame rx_data is correct from its bit 0.
- Backpressure:
  - stimulus: tx_valid held high with successive values across a 3-word burst.
  - response: exactly one acceptance per word load; tx_ready low between accept and load.
- Reset:
  - stimulus: assert reset mid-word in mode 1.
  - response: all outputs read reset values in the same cycle; a subsequent clean frame transfers correctly.
